// File: rtl/paddle_ctrl.sv
// rtl/paddle_ctrl.sv - multi-player paddle position controller with auto-repeat and CPU tracking
module paddle_ctrl #(
  parameter int NUM_PLAYERS  = 2,
  parameter int POS_WIDTH    = 3,
  parameter int FIELD_WIDTH  = 8,
  parameter int PADDLE_SIZE  = 2,
  parameter int START_POS    = 3,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [NUM_PLAYERS-1:0]         btn_left,
  input  logic [NUM_PLAYERS-1:0]         btn_right,
  input  logic [NUM_PLAYERS-1:0]         auto_mode,
  input  logic [POS_WIDTH-1:0]           ball_x,
  input  logic                           tick,
  output logic [NUM_PLAYERS*POS_WIDTH-1:0] pos_flat,
  output logic [NUM_PLAYERS-1:0]         moved,
  output logic [NUM_PLAYERS-1:0]         at_left_edge,
  output logic [NUM_PLAYERS-1:0]         at_right_edge
);

  localparam int MAX_POS = FIELD_WIDTH - PADDLE_SIZE;

  // Extended-width constants so edge compares never wrap.
  localparam logic [POS_WIDTH:0]   MAX_EXT    = (POS_WIDTH+1)'(MAX_POS);
  localparam logic [POS_WIDTH:0]   HALF_EXT   = (POS_WIDTH+1)'(PADDLE_SIZE / 2);
  localparam logic [POS_WIDTH-1:0] MAX_Q      = POS_WIDTH'(MAX_POS);
  localparam logic [POS_WIDTH-1:0] START_Q    = POS_WIDTH'(START_POS);
  localparam logic [CNT_WIDTH-1:0] DELAY_LAST = CNT_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] RATE_LAST  = CNT_WIDTH'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  logic [POS_WIDTH:0] ball_ext;
  assign ball_ext = {1'b0, ball_x};

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_ch
    logic [POS_WIDTH-1:0] pos_q;
    state_t               state_q;
    logic                 dir_q;       // latched direction, 1 = right
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 moved_q;

    logic                 dir_none;
    logic                 dir_right;
    logic                 step_req;
    logic                 step_right;
    logic                 step_ok;
    logic [POS_WIDTH:0]   pos_ext;
    logic [POS_WIDTH:0]   centre;

    // Decide whether this edge wants a step, in which direction, and whether the field allows it.
    always_comb begin
      dir_none   = (btn_left[i] == btn_right[i]);
      dir_right  = btn_right[i];
      pos_ext    = {1'b0, pos_q};
      centre     = pos_ext + HALF_EXT;
      step_req   = 1'b0;
      step_right = dir_right;
      if (auto_mode[i]) begin
        step_req   = tick && (ball_ext != centre);
        step_right = (ball_ext > centre);
      end else if (!dir_none) begin
        case (state_q)
          S_IDLE:  step_req = 1'b1;
          S_DELAY: step_req = (dir_right != dir_q) || (cnt_q == DELAY_LAST);
          default: step_req = (dir_right != dir_q) || (cnt_q == RATE_LAST);
        endcase
      end
      step_ok = step_right ? ((pos_ext + 1'b1) <= MAX_EXT) : (pos_ext != '0);
    end

    // Position register plus the press / delay / repeat state machine.
    always_ff @(posedge clk) begin
      if (rst || !en) begin
        pos_q   <= START_Q;
        state_q <= S_IDLE;
        dir_q   <= 1'b0;
        cnt_q   <= '0;
        moved_q <= 1'b0;
      end else begin
        moved_q <= step_req && step_ok;
        if (step_req && step_ok) begin
          pos_q <= step_right ? pos_q + 1'b1 : pos_q - 1'b1;
        end
        if (auto_mode[i] || dir_none) begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end else if (state_q == S_IDLE || dir_right != dir_q) begin
          dir_q   <= dir_right;
          cnt_q   <= '0;
          state_q <= S_DELAY;
        end else if (state_q == S_DELAY) begin
          if (cnt_q == DELAY_LAST) begin
            cnt_q   <= '0;
            state_q <= S_REPEAT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end else begin
          if (cnt_q == RATE_LAST) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      end
    end

    assign pos_flat[i*POS_WIDTH +: POS_WIDTH] = pos_q;
    assign moved[i]         = moved_q;
    assign at_left_edge[i]  = (pos_q == '0);
    assign at_right_edge[i] = (pos_q == MAX_Q);
  end

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb/tb_paddle_ctrl.sv - scoreboard testbench for paddle_ctrl against a hold-age reference model
module tb_paddle_ctrl;

  localparam int NP    = 2;
  localparam int PW    = 3;
  localparam int FW    = 8;
  localparam int PS    = 2;
  localparam int START = 3;
  localparam int RD    = 8;
  localparam int RR    = 4;
  localparam int CW    = 8;
  localparam int MAXP  = FW - PS;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [NP-1:0]     btn_left;
  logic [NP-1:0]     btn_right;
  logic [NP-1:0]     auto_mode;
  logic [PW-1:0]     ball_x;
  logic              tick;
  logic [NP*PW-1:0]  pos_flat;
  logic [NP-1:0]     moved;
  logic [NP-1:0]     at_left_edge;
  logic [NP-1:0]     at_right_edge;

  paddle_ctrl #(
    .NUM_PLAYERS(NP), .POS_WIDTH(PW), .FIELD_WIDTH(FW), .PADDLE_SIZE(PS),
    .START_POS(START), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .btn_left(btn_left), .btn_right(btn_right), .auto_mode(auto_mode),
    .ball_x(ball_x), .tick(tick),
    .pos_flat(pos_flat), .moved(moved),
    .at_left_edge(at_left_edge), .at_right_edge(at_right_edge)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NP*PW-1:0] pf;
    logic [NP-1:0]    mv;
    logic [NP-1:0]    le;
    logic [NP-1:0]    re;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: position, the direction currently held, and how many edges it has been held.
  int m_pos[NP];
  int m_hold[NP];   // 0 none, 1 left, 2 right
  int m_age[NP];

  task automatic model_edge();
    exp_t e;
    for (int i = 0; i < NP; i++) begin
      int  d;
      int  c;
      bit  mv;
      bit  want;
      int  target;
      mv = 1'b0;
      if (rst || !en) begin
        m_pos[i]  = START;
        m_hold[i] = 0;
        m_age[i]  = 0;
      end else if (auto_mode[i]) begin
        m_hold[i] = 0;
        m_age[i]  = 0;
        if (tick) begin
          c = m_pos[i] + PS / 2;
          if (int'(ball_x) < c && m_pos[i] > 0) begin
            m_pos[i]--; mv = 1'b1;
          end else if (int'(ball_x) > c && m_pos[i] < MAXP) begin
            m_pos[i]++; mv = 1'b1;
          end
        end
      end else begin
        d = (btn_left[i] && !btn_right[i]) ? 1 : (!btn_left[i] && btn_right[i]) ? 2 : 0;
        if (d == 0) begin
          m_hold[i] = 0;
          m_age[i]  = 0;
        end else begin
          if (d != m_hold[i]) begin
            m_hold[i] = d;
            m_age[i]  = 0;
          end else begin
            m_age[i]++;
          end
          want = (m_age[i] == 0) || (m_age[i] >= RD && ((m_age[i] - RD) % RR) == 0);
          if (want) begin
            target = (d == 1) ? m_pos[i] - 1 : m_pos[i] + 1;
            if (target >= 0 && target <= MAXP) begin
              m_pos[i] = target; mv = 1'b1;
            end
          end
        end
      end
      e.pf[i*PW +: PW] = PW'(m_pos[i]);
      e.mv[i] = mv;
      e.le[i] = (m_pos[i] == 0);
      e.re[i] = (m_pos[i] == MAXP);
    end
    sb_q.push_back(e);
  endtask

  // One clock: predict the outcome of the upcoming edge, then let it happen.
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      model_edge();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: after each edge pop the prediction for that edge and compare all outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("pos_flat",      32'(pos_flat),      32'(e.pf));
        check("moved",         32'(moved),         32'(e.mv));
        check("at_left_edge",  32'(at_left_edge),  32'(e.le));
        check("at_right_edge", 32'(at_right_edge), 32'(e.re));
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; btn_left = '0; btn_right = '0;
    auto_mode = '0; ball_x = '0; tick = 1'b0;
    for (int i = 0; i < NP; i++) begin
      m_pos[i] = START; m_hold[i] = 0; m_age[i] = 0;
    end
    cyc(2);
    rst = 1'b0; en = 1'b1;
    cyc(3);
    // single tap on player 0
    btn_left = 2'b01; cyc(1);
    btn_left = 2'b00; cyc(2);
    // player 1 held right: delay, repeats, then clamp
    btn_right = 2'b10; cyc(20);
    btn_right = 2'b00; cyc(2);
    // player 0: left hold, reversal, then both buttons
    btn_left = 2'b01; cyc(5);
    btn_left = 2'b00; btn_right = 2'b01; cyc(10);
    btn_left = 2'b01; btn_right = 2'b01; cyc(3);
    btn_left = 2'b00; btn_right = 2'b00; cyc(1);
    // player 0 held left into the clamp
    btn_left = 2'b01; cyc(30);
    // disable mid-hold, then rst mid-hold
    en = 1'b0; cyc(2);
    en = 1'b1; cyc(10);
    rst = 1'b1; cyc(1);
    rst = 1'b0; btn_left = 2'b00; cyc(1);
    // CPU mode on player 1 chasing ball_x = 0 while its buttons are pressed
    auto_mode = 2'b10; ball_x = '0; btn_right = 2'b10;
    for (int t = 0; t < 6; t++) begin
      tick = 1'b1; cyc(1);
      tick = 1'b0; cyc(2);
    end
    // back to manual with the button still held: fresh press
    auto_mode = 2'b00; cyc(3);
    btn_right = 2'b00; cyc(1);

    // randomized phase with held buttons and occasional mode/enable changes
    for (int r = 0; r < 3000; r++) begin
      for (int i = 0; i < NP; i++) begin
        if ($urandom_range(0, 7) == 0) btn_left[i]  = $urandom_range(0, 1);
        if ($urandom_range(0, 7) == 0) btn_right[i] = $urandom_range(0, 1);
        if ($urandom_range(0, 63) == 0) auto_mode[i] = ~auto_mode[i];
      end
      tick   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) ball_x = PW'($urandom_range(0, 7));
      en     = ($urandom_range(0, 199) != 0);
      rst    = ($urandom_range(0, 499) == 0);
      cyc(1);
    end

    @(posedge clk);
    #3;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
